// File: rtl/cmp_stream_unit_if.sv
// cmp_stream_unit_if: handshake and payload bundle for cmp_stream_unit.
//   Input side : in_valid, in_ready, x, y, mode (and is_signed when CMP_SIGNED_EN)
//   Output side: out_valid, out_ready, out, flags, acc_valid, match_cnt
//   master = producer/consumer environment, slave = the compare unit.
// Optional macro: CMP_SIGNED_EN adds the is_signed select.
interface cmp_stream_unit_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [2:0]       mode;
`ifdef CMP_SIGNED_EN
   logic             is_signed;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic [2:0]       flags;
   logic             acc_valid;
   logic [CNT_W-1:0] match_cnt;

`ifdef CMP_SIGNED_EN
   modport master (
      output in_valid, x, y, mode, is_signed, out_ready,
      input  in_ready, out_valid, out, flags, acc_valid, match_cnt
   );
   modport slave (
      input  in_valid, x, y, mode, is_signed, out_ready,
      output in_ready, out_valid, out, flags, acc_valid, match_cnt
   );
`else
   modport master (
      output in_valid, x, y, mode, out_ready,
      input  in_ready, out_valid, out, flags, acc_valid, match_cnt
   );
   modport slave (
      input  in_valid, x, y, mode, out_ready,
      output in_ready, out_valid, out, flags, acc_valid, match_cnt
   );
`endif
endinterface

// File: rtl/cmp_stream_unit.sv
// cmp_stream_unit: registered streaming comparator with running extremum
// accumulator and saturating equality-match counter.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : cmp_stream_unit_if.slave (valid/ready input and output sides,
//          result, flags {lt,gt,eq}, acc_valid, match_cnt)
// Optional macro: CMP_SIGNED_EN enables two's complement compares via is_signed.
module cmp_stream_unit #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
) (
   input logic              clk,
   input logic              rst,
   cmp_stream_unit_if.slave bus
);
   localparam logic [2:0] MODE_EQ   = 3'd0;
   localparam logic [2:0] MODE_GT   = 3'd1;
   localparam logic [2:0] MODE_LT   = 3'd2;
   localparam logic [2:0] MODE_MAX  = 3'd3;
   localparam logic [2:0] MODE_MIN  = 3'd4;
   localparam logic [2:0] MODE_RMAX = 3'd5;
   localparam logic [2:0] MODE_RMIN = 3'd6;
   localparam logic [2:0] MODE_CLR  = 3'd7;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] out_q, acc_q, out_d, acc_d;
   logic [2:0]       flags_q, flags_d;
   logic             out_valid_q, acc_valid_q, acc_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sgn, ready, xfer;
   logic             lt, gt, eq, acc_gt_x, acc_lt_x;
   logic [WIDTH-1:0] x_k, y_k, acc_k;

`ifdef CMP_SIGNED_EN
   assign sgn = bus.is_signed;
`else
   assign sgn = 1'b0;
`endif

   // Inverting the MSB maps two's complement order onto unsigned order.
   assign x_k   = {bus.x[WIDTH-1] ^ sgn, bus.x[WIDTH-2:0]};
   assign y_k   = {bus.y[WIDTH-1] ^ sgn, bus.y[WIDTH-2:0]};
   assign acc_k = {acc_q[WIDTH-1] ^ sgn, acc_q[WIDTH-2:0]};

   assign eq       = (bus.x == bus.y);
   assign gt       = (x_k > y_k);
   assign lt       = (x_k < y_k);
   assign acc_gt_x = (acc_k > x_k);
   assign acc_lt_x = (acc_k < x_k);

   // No skid buffer: accept only when the output slot is free or draining.
   assign ready = !out_valid_q || bus.out_ready;
   assign xfer  = bus.in_valid && ready;

   // Result, accumulator and counter values for the transaction on the bus.
   always_comb begin
      out_d       = '0;
      flags_d     = {lt, gt, eq};
      acc_d       = acc_q;
      acc_valid_d = acc_valid_q;
      cnt_d       = (eq && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
      case (bus.mode)
         MODE_EQ:  out_d = {{(WIDTH-1){1'b0}}, eq};
         MODE_GT:  out_d = {{(WIDTH-1){1'b0}}, gt};
         MODE_LT:  out_d = {{(WIDTH-1){1'b0}}, lt};
         MODE_MAX: out_d = gt ? bus.x : bus.y;
         MODE_MIN: out_d = lt ? bus.x : bus.y;
         MODE_RMAX: begin
            acc_d       = (acc_valid_q && acc_gt_x) ? acc_q : bus.x;
            acc_valid_d = 1'b1;
            out_d       = acc_d;
         end
         MODE_RMIN: begin
            acc_d       = (acc_valid_q && acc_lt_x) ? acc_q : bus.x;
            acc_valid_d = 1'b1;
            out_d       = acc_d;
         end
         MODE_CLR: begin
            flags_d     = 3'b000;
            acc_d       = '0;
            acc_valid_d = 1'b0;
            cnt_d       = '0;
         end
         default: out_d = '0;
      endcase
   end

   // Output slot plus accumulator/counter state; acc and count move on transfer only.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
         flags_q     <= 3'b000;
         acc_q       <= '0;
         acc_valid_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         if (xfer) begin
            out_valid_q <= 1'b1;
            out_q       <= out_d;
            flags_q     <= flags_d;
            acc_q       <= acc_d;
            acc_valid_q <= acc_valid_d;
            cnt_q       <= cnt_d;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out       = out_q;
   assign bus.flags     = flags_q;
   assign bus.acc_valid = acc_valid_q;
   assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_cmp_stream_unit.sv
// tb_cmp_stream_unit: directed table, corner sequences and randomized run
// against a behavioural model for cmp_stream_unit (WIDTH=8, CNT_W=8 and 2).
module tb_cmp_stream_unit;
   localparam logic [2:0] EQ = 3'd0, GT = 3'd1, LT = 3'd2, MX = 3'd3;
   localparam logic [2:0] MN = 3'd4, RMX = 3'd5, RMN = 3'd6, CLR = 3'd7;

   logic clk, rst;
   int   n_pass, n_total;

   cmp_stream_unit_if #(.WIDTH(8), .CNT_W(8)) ifc ();
   cmp_stream_unit_if #(.WIDTH(8), .CNT_W(2)) ifc2 ();

   cmp_stream_unit #(.WIDTH(8), .CNT_W(8)) u_dut  (.clk(clk), .rst(rst), .bus(ifc));
   cmp_stream_unit #(.WIDTH(8), .CNT_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(ifc2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] mode;
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] eo;
      logic [2:0] ef;
      int         ecnt;
      bit         eaccv;
   } vec_t;
   vec_t tbl [12];

   // behavioural model state
   logic [7:0] m_acc;
   bit         m_accv;
   int         m_cnt;
   bit         m_ov;
   logic [7:0] m_out;
   logic [2:0] m_flags;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic int ival(input logic [7:0] v, input bit sg);
      return sg ? int'($signed(v)) : int'(v);
   endfunction

   // Transaction semantics computed on integers.
   function automatic void model_xfer(input logic [2:0] md, input logic [7:0] a,
                                      input logic [7:0] b, input bit sg,
                                      output logic [7:0] r, output logic [2:0] f);
      int ia, ib, iacc;
      bit l, g, e;
      ia = ival(a, sg); ib = ival(b, sg); iacc = ival(m_acc, sg);
      l = ia < ib; g = ia > ib; e = (a == b);
      f = {l, g, e};
      r = 8'd0;
      case (md)
         EQ:  r = {7'd0, e};
         GT:  r = {7'd0, g};
         LT:  r = {7'd0, l};
         MX:  r = g ? a : b;
         MN:  r = l ? a : b;
         RMX: begin
            if (!m_accv || ia > iacc) m_acc = a;
            m_accv = 1; r = m_acc;
         end
         RMN: begin
            if (!m_accv || ia < iacc) m_acc = a;
            m_accv = 1; r = m_acc;
         end
         default: begin
            m_acc = 8'd0; m_accv = 0; m_cnt = 0; f = 3'b000; r = 8'd0;
         end
      endcase
      if (md != CLR && e && m_cnt < 255) m_cnt++;
   endfunction

   task automatic xfer(input logic [2:0] md, input logic [7:0] a, input logic [7:0] b);
      ifc.mode = md; ifc.x = a; ifc.y = b;
      ifc.in_valid = 1'b1; ifc.out_ready = 1'b1;
      @(posedge clk); #1;
      ifc.in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      rst = 1'b1;
      ifc.in_valid = 0; ifc.x = 0; ifc.y = 0; ifc.mode = 0; ifc.out_ready = 1;
      ifc2.in_valid = 0; ifc2.x = 0; ifc2.y = 0; ifc2.mode = 0; ifc2.out_ready = 1;
`ifdef CMP_SIGNED_EN
      ifc.is_signed = 0; ifc2.is_signed = 0;
`endif
      tbl[0]  = '{MX,  8'h3C, 8'hA5, 8'hA5, 3'b100, 0, 0};
      tbl[1]  = '{EQ,  8'h55, 8'h55, 8'h01, 3'b001, 1, 0};
      tbl[2]  = '{GT,  8'h55, 8'h55, 8'h00, 3'b001, 2, 0};
      tbl[3]  = '{LT,  8'h55, 8'h55, 8'h00, 3'b001, 3, 0};
      tbl[4]  = '{EQ,  8'h10, 8'h20, 8'h00, 3'b100, 3, 0};
      tbl[5]  = '{GT,  8'h10, 8'h20, 8'h00, 3'b100, 3, 0};
      tbl[6]  = '{LT,  8'h10, 8'h20, 8'h01, 3'b100, 3, 0};
      tbl[7]  = '{RMX, 8'd5,   8'd0, 8'd5,   3'b010, 3, 1};
      tbl[8]  = '{RMX, 8'd200, 8'd0, 8'd200, 3'b010, 3, 1};
      tbl[9]  = '{RMX, 8'd17,  8'd0, 8'd200, 3'b010, 3, 1};
      tbl[10] = '{RMN, 8'd9,   8'd0, 8'd9,   3'b010, 3, 1};
      tbl[11] = '{CLR, 8'd4,   8'd4, 8'd0,   3'b000, 0, 0};

      @(posedge clk); @(posedge clk); #1;
      check("rst_out_valid", ifc.out_valid, 0);
      check("rst_out", ifc.out, 0);
      check("rst_flags", ifc.flags, 0);
      check("rst_acc_valid", ifc.acc_valid, 0);
      check("rst_match_cnt", ifc.match_cnt, 0);
      rst = 1'b0;
      check("rst_in_ready", ifc.in_ready, 1);

      // directed table
      for (int i = 0; i < 12; i++) begin
         xfer(tbl[i].mode, tbl[i].x, tbl[i].y);
         check($sformatf("tbl%0d_out_valid", i), ifc.out_valid, 1);
         check($sformatf("tbl%0d_out", i), ifc.out, tbl[i].eo);
         check($sformatf("tbl%0d_flags", i), ifc.flags, tbl[i].ef);
         check($sformatf("tbl%0d_match_cnt", i), ifc.match_cnt, tbl[i].ecnt);
         check($sformatf("tbl%0d_acc_valid", i), ifc.acc_valid, tbl[i].eaccv);
         if (i == 0) begin
            @(posedge clk); #1;
            check("pulse_out_valid", ifc.out_valid, 0);
            check("retire_out_kept", ifc.out, 8'hA5);
            check("retire_flags_kept", ifc.flags, 3'b100);
         end
      end

      // stall: result held, input blocked, no state change
      xfer(EQ, 8'd7, 8'd7);
      check("stall_pre_cnt", ifc.match_cnt, 1);
      ifc.out_ready = 0; ifc.in_valid = 1; ifc.mode = RMX; ifc.x = 8'd99; ifc.y = 8'd99;
      for (int c = 0; c < 4; c++) begin
         #0;
         check("stall_in_ready", ifc.in_ready, 0);
         @(posedge clk); #1;
         check("stall_out_valid", ifc.out_valid, 1);
         check("stall_out", ifc.out, 1);
         check("stall_cnt", ifc.match_cnt, 1);
         check("stall_acc_valid", ifc.acc_valid, 0);
      end
      ifc.out_ready = 1;
      #1;
      check("unstall_in_ready", ifc.in_ready, 1);
      @(posedge clk); #1;
      ifc.in_valid = 0;
      check("unstall_out_valid", ifc.out_valid, 1);
      check("unstall_out", ifc.out, 99);
      check("unstall_cnt", ifc.match_cnt, 2);
      check("unstall_acc_valid", ifc.acc_valid, 1);

      // reset while a result is held under stall
      xfer(EQ, 8'd3, 8'd3);
      ifc.out_ready = 0;
      @(posedge clk); #1;
      check("hold_before_rst", ifc.out_valid, 1);
      do_reset();
      check("rst2_out_valid", ifc.out_valid, 0);
      check("rst2_acc_valid", ifc.acc_valid, 0);
      check("rst2_cnt", ifc.match_cnt, 0);
      check("rst2_in_ready", ifc.in_ready, 1);
      ifc.out_ready = 1;

      // narrow counter saturation
      for (int i = 0; i < 5; i++) begin
         ifc2.mode = EQ; ifc2.x = 8'(i * 3); ifc2.y = 8'(i * 3); ifc2.in_valid = 1;
         @(posedge clk); #1;
         check($sformatf("cnt2_step%0d", i), ifc2.match_cnt, (i < 3) ? i + 1 : 3);
      end
      ifc2.in_valid = 0;

`ifdef CMP_SIGNED_EN
      ifc.is_signed = 1;
      xfer(GT, 8'hFF, 8'h01);
      check("signed_gt_out", ifc.out, 0);
      check("signed_gt_flags", ifc.flags, 3'b100);
      ifc.is_signed = 0;
`endif

      // randomized run against the model
      do_reset();
      m_acc = 0; m_accv = 0; m_cnt = 0; m_ov = 0; m_out = 0; m_flags = 0;
      for (int i = 0; i < 400; i++) begin
         bit iv, ordy, sg, erdy;
         logic [2:0] md, f;
         logic [7:0] a, b, r;
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 9) < 7);
         md   = 3'($urandom_range(0, 7));
         if (md == CLR && $urandom_range(0, 1) == 1) md = RMX;
         a    = 8'($urandom);
         b    = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
         sg   = 0;
`ifdef CMP_SIGNED_EN
         sg = 1'($urandom);
         ifc.is_signed = sg;
`endif
         ifc.in_valid = iv; ifc.out_ready = ordy; ifc.mode = md; ifc.x = a; ifc.y = b;
         erdy = !m_ov || ordy;
         #1;
         check("rnd_in_ready", ifc.in_ready, erdy);
         @(posedge clk); #1;
         if (iv && erdy) begin
            model_xfer(md, a, b, sg, r, f);
            m_ov = 1; m_out = r; m_flags = f;
         end else if (ordy) begin
            m_ov = 0;
         end
         check("rnd_out_valid", ifc.out_valid, m_ov);
         check("rnd_out", ifc.out, m_out);
         check("rnd_flags", ifc.flags, m_flags);
         check("rnd_match_cnt", ifc.match_cnt, m_cnt);
         check("rnd_acc_valid", ifc.acc_valid, m_accv);
      end
      ifc.in_valid = 0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
